// File: rtl/pipe_stage_skid.sv
// ----------------------------------------------------------------------------
// pipe_stage_skid
//
// Purpose:
//   A pipeline stage register with a valid/ready handshake and a 2-entry skid
//   buffer. It carries an opaque DATA_W-bit payload between two CPU pipeline
//   stages (ID/EX, EX/MEM, MEM/WB). Upstream and downstream can stall on their
//   own without losing full throughput. A synchronous flush discards
//   everything held and leaves a NOP bubble. Two saturating counters record
//   downstream bubbles and upstream back-pressure.
//
// Parameters:
//   DATA_W     payload width
//   NOP_VALUE  payload presented on out_data whenever out_valid is low
//   CNT_W      width of each performance counter
//
// Ports:
//   clk         clock; all state updates on the rising edge
//   rst         synchronous, active-high reset
//   flush       synchronous flush; drops held entries and any same-cycle push
//   in_valid    upstream payload valid
//   in_ready    stage can accept (derived only from registered state)
//   in_data     upstream payload
//   out_valid   payload on out_data is valid
//   out_ready   downstream accepts this cycle
//   out_data    payload to the next stage
//   occupancy   number of held entries, 0..2
//   bubble_cnt  cycles with out_ready=1 and out_valid=0, saturating
//   backpr_cnt  cycles with in_valid=1 and in_ready=0, saturating
// ----------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int                 DATA_W    = 110,
    parameter logic [DATA_W-1:0]  NOP_VALUE = {DATA_W{1'b0}},
    parameter int                 CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  backpr_cnt
);

    // The encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_next;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_next;
    logic              push;
    logic              pop;

    // Handshake flags come only from the state register. This avoids any
    // combinational path from out_ready to in_ready or from in_valid to
    // out_valid.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign occupancy = state;

    // main_q is forced to NOP_VALUE on every entry to EMPTY, so it can drive
    // the output directly.
    assign out_data  = main_q;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Next-state logic. A flush wins over the handshake and discards any
    // same-cycle push. A same-cycle pop has already been seen downstream, so
    // it still counts as delivered.
    always_comb begin
        state_next = state;
        main_next  = main_q;
        skid_next  = skid_q;
        if (flush) begin
            state_next = EMPTY;
            main_next  = NOP_VALUE;
            skid_next  = NOP_VALUE;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        state_next = ONE;
                        main_next  = in_data;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        state_next = FULL;
                        skid_next  = in_data;
                    end else if (push && pop) begin
                        main_next  = in_data;
                    end else if (pop) begin
                        state_next = EMPTY;
                        main_next  = NOP_VALUE;
                    end
                end
                FULL: begin
                    // No push is possible here. The skid entry moves up so
                    // that FIFO order is kept.
                    if (pop) begin
                        state_next = ONE;
                        main_next  = skid_q;
                        skid_next  = NOP_VALUE;
                    end
                end
                default: begin
                    state_next = EMPTY;
                    main_next  = NOP_VALUE;
                    skid_next  = NOP_VALUE;
                end
            endcase
        end
    end

    // State and payload registers. Reset takes priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= NOP_VALUE;
            skid_q <= NOP_VALUE;
        end else begin
            state  <= state_next;
            main_q <= main_next;
            skid_q <= skid_next;
        end
    end

    // Performance counters. They sample the same-cycle handshake values and
    // stick at all-ones. Only reset clears them; a flush leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
            backpr_cnt <= '0;
        end else begin
            if (out_ready && !out_valid && (bubble_cnt != {CNT_W{1'b1}}))
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            if (in_valid && !in_ready && (backpr_cnt != {CNT_W{1'b1}}))
                backpr_cnt <= backpr_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// ----------------------------------------------------------------------------
// tb_pipe_stage_skid
//
// Purpose:
//   Directed testbench for pipe_stage_skid. It covers streaming,
//   back-pressure, simultaneous push/pop, flush, mid-stream reset and counter
//   saturation. Every expected value is hand-computed.
//   A second instance with 4-bit counters checks saturation.
//
// Ports: none (top-level bench)
// ----------------------------------------------------------------------------
module tb_pipe_stage_skid;

    localparam int DATA_W = 110;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  bubble_cnt;
    logic [CNT_W-1:0]  backpr_cnt;

    // The second instance has small counters and is used only for the
    // saturation check.
    logic              sat_in_ready;
    logic              sat_out_valid;
    logic              sat_out_ready;
    logic [7:0]        sat_out_data;
    logic [1:0]        sat_occupancy;
    logic [3:0]        sat_bubble_cnt;
    logic [3:0]        sat_backpr_cnt;

    int checkCount;
    int passCount;

    pipe_stage_skid #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .occupancy  (occupancy),
        .bubble_cnt (bubble_cnt),
        .backpr_cnt (backpr_cnt)
    );

    pipe_stage_skid #(.DATA_W(8), .CNT_W(4)) sat_dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (1'b0),
        .in_valid   (1'b0),
        .in_ready   (sat_in_ready),
        .in_data    (8'h00),
        .out_valid  (sat_out_valid),
        .out_ready  (sat_out_ready),
        .out_data   (sat_out_data),
        .occupancy  (sat_occupancy),
        .bubble_cnt (sat_bubble_cnt),
        .backpr_cnt (sat_backpr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares one observed value against its expected value and keeps the
    // running tallies.
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Waits for one rising edge, then lets outputs settle before the caller
    // samples them or drives new inputs.
    task automatic applyStimulus(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Checks the full set of reset-state outputs.
    task automatic checkResetState(input string tag);
        checkOutput({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        checkOutput({tag, "_in_ready"},  128'(in_ready),  128'(1));
        checkOutput({tag, "_out_data"},  128'(out_data),  128'(0));
        checkOutput({tag, "_occ"},       128'(occupancy), 128'(0));
        checkOutput({tag, "_bubble"},    128'(bubble_cnt), 128'(0));
        checkOutput({tag, "_backpr"},    128'(backpr_cnt), 128'(0));
    endtask

    initial begin
        checkCount    = 0;
        passCount     = 0;
        rst           = 1'b1;
        flush         = 1'b0;
        in_valid      = 1'b0;
        in_data       = '0;
        out_ready     = 1'b0;
        sat_out_ready = 1'b0;

        // Reset state
        applyStimulus(2);
        rst = 1'b0;
        checkResetState("reset");

        // Streaming: input i is visible right after the edge that pushes it.
        // Only the first cycle, while the stage is empty, counts as a bubble.
        for (int i = 1; i <= 8; i++) begin
            in_valid  = 1'b1;
            in_data   = DATA_W'(i);
            out_ready = 1'b1;
            applyStimulus(1);
            checkOutput($sformatf("stream_data%0d", i), 128'(out_data), 128'(i));
            checkOutput($sformatf("stream_occ%0d", i), 128'(occupancy), 128'(1));
        end
        checkOutput("stream_bubble", 128'(bubble_cnt), 128'(1));
        checkOutput("stream_backpr", 128'(backpr_cnt), 128'(0));
        in_valid = 1'b0;
        applyStimulus(1);
        checkOutput("stream_drain_valid", 128'(out_valid), 128'(0));
        out_ready = 1'b0;

        // Back-pressure: fill with A and B, then offer C for three cycles
        in_valid = 1'b1;
        in_data  = DATA_W'(8'hA);
        applyStimulus(1);
        in_data  = DATA_W'(8'hB);
        applyStimulus(1);
        checkOutput("bp_occ_full", 128'(occupancy), 128'(2));
        checkOutput("bp_in_ready", 128'(in_ready), 128'(0));
        in_data  = DATA_W'(8'hC);
        applyStimulus(3);
        checkOutput("bp_backpr3", 128'(backpr_cnt), 128'(3));
        checkOutput("bp_hold_A", 128'(out_data), 128'(8'hA));
        // The pop of A still sees in_ready=0, so back-pressure counts once more.
        out_ready = 1'b1;
        applyStimulus(1);
        checkOutput("bp_out_B", 128'(out_data), 128'(8'hB));
        checkOutput("bp_in_ready_back", 128'(in_ready), 128'(1));
        applyStimulus(1);
        checkOutput("bp_out_C", 128'(out_data), 128'(8'hC));
        in_valid = 1'b0;
        applyStimulus(1);
        checkOutput("bp_empty_valid", 128'(out_valid), 128'(0));
        checkOutput("bp_empty_nop", 128'(out_data), 128'(0));
        checkOutput("bp_backpr4", 128'(backpr_cnt), 128'(4));
        checkOutput("bp_bubble", 128'(bubble_cnt), 128'(1));
        out_ready = 1'b0;

        // Simultaneous push and pop while holding one entry
        in_valid = 1'b1;
        in_data  = DATA_W'(8'h5);
        applyStimulus(1);
        checkOutput("pp_main5", 128'(out_data), 128'(8'h5));
        in_data   = DATA_W'(8'h6);
        out_ready = 1'b1;
        applyStimulus(1);
        checkOutput("pp_out6", 128'(out_data), 128'(8'h6));
        checkOutput("pp_occ", 128'(occupancy), 128'(1));

        // Flush while full with a push offered. The offered push meets
        // in_ready=0, so back-pressure goes 4 -> 5.
        out_ready = 1'b0;
        in_data   = DATA_W'(8'h11);
        applyStimulus(1);
        checkOutput("fl_occ_full", 128'(occupancy), 128'(2));
        flush    = 1'b1;
        in_data  = DATA_W'(8'h7);
        applyStimulus(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("fl_valid", 128'(out_valid), 128'(0));
        checkOutput("fl_nop", 128'(out_data), 128'(0));
        checkOutput("fl_occ", 128'(occupancy), 128'(0));
        checkOutput("fl_in_ready", 128'(in_ready), 128'(1));
        checkOutput("fl_bubble", 128'(bubble_cnt), 128'(1));
        checkOutput("fl_backpr", 128'(backpr_cnt), 128'(5));
        // Nothing must show up afterwards, and 0x7 in particular must not.
        out_ready = 1'b1;
        applyStimulus(1);
        checkOutput("fl_no7_valid", 128'(out_valid), 128'(0));
        checkOutput("fl_bubble2", 128'(bubble_cnt), 128'(2));
        out_ready = 1'b0;

        // Reset mid-stream while full, with flush and push in the same cycle
        in_valid = 1'b1;
        in_data  = DATA_W'(8'h21);
        applyStimulus(1);
        in_data  = DATA_W'(8'h22);
        applyStimulus(1);
        checkOutput("rs_occ_full", 128'(occupancy), 128'(2));
        rst     = 1'b1;
        flush   = 1'b1;
        in_data = DATA_W'(8'h23);
        applyStimulus(1);
        rst     = 1'b0;
        flush   = 1'b0;
        checkResetState("midreset");
        in_data = DATA_W'(8'h9);
        applyStimulus(1);
        in_valid = 1'b0;
        checkOutput("rs_push9_valid", 128'(out_valid), 128'(1));
        checkOutput("rs_push9_data", 128'(out_data), 128'(8'h9));
        checkOutput("rs_push9_occ", 128'(occupancy), 128'(1));

        // Saturation on the 4-bit counter instance
        checkOutput("sat_start", 128'(sat_bubble_cnt), 128'(0));
        sat_out_ready = 1'b1;
        applyStimulus(10);
        checkOutput("sat_cnt10", 128'(sat_bubble_cnt), 128'(10));
        applyStimulus(10);
        checkOutput("sat_cnt15", 128'(sat_bubble_cnt), 128'(15));
        checkOutput("sat_backpr", 128'(sat_backpr_cnt), 128'(0));
        sat_out_ready = 1'b0;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
